// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame reader: 640x480@60 timing defaults,
// the 300x300 image window placement and the image memory address map.
package vga_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_WIN_X0 = 170;
    localparam int DEF_WIN_Y0 = 90;
    localparam int DEF_WIN_W  = 300;
    localparam int DEF_WIN_H  = 300;

    localparam int          DEF_READ_LATENCY = 2;
    localparam logic [23:0] DEF_BG_COLOR     = 24'h000000;

    localparam int ADDR_W        = 17;
    localparam int IMG_ROM_BASE  = 0;
    localparam int DATA_RAM_BASE = 90000;
    localparam int IMG_PIXELS    = 90000;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Per-pixel timing flags carried alongside the memory read latency.
    typedef struct packed {
        logic visible;
        logic hs_n;
        logic vs_n;
        logic in_win;
        logic first;
    } tflags_t;

    localparam tflags_t FLAGS_IDLE = '{visible: 1'b0, hs_n: 1'b1, vs_n: 1'b1,
                                       in_win: 1'b0, first: 1'b0};

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical position counters and the raw (undelayed) timing flags
// decoded from the current counter position.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int WIN_X0    = DEF_WIN_X0,
    parameter int WIN_Y0    = DEF_WIN_Y0,
    parameter int WIN_W     = DEF_WIN_W,
    parameter int WIN_H     = DEF_WIN_H
) (
    input  logic clk,
    input  logic reset,
    output logic visible,
    output logic hs_n,
    output logic vs_n,
    output logic in_win,
    output logic first,
    output logic frame_end
);

    localparam int HT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    typedef logic [HW-1:0] h_t;
    typedef logic [VW-1:0] v_t;

    localparam h_t H_LAST   = h_t'(HT - 1);
    localparam v_t V_LAST   = v_t'(VT - 1);
    localparam h_t H_VIS_E  = h_t'(H_VISIBLE);
    localparam v_t V_VIS_E  = v_t'(V_VISIBLE);
    localparam h_t HS_START = h_t'(H_VISIBLE + H_FP);
    localparam h_t HS_END   = h_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam v_t VS_START = v_t'(V_VISIBLE + V_FP);
    localparam v_t VS_END   = v_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam h_t WX_START = h_t'(WIN_X0);
    localparam h_t WX_END   = h_t'(WIN_X0 + WIN_W);
    localparam v_t WY_START = v_t'(WIN_Y0);
    localparam v_t WY_END   = v_t'(WIN_Y0 + WIN_H);

    h_t h_cnt;
    v_t v_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        visible   = (h_cnt < H_VIS_E) && (v_cnt < V_VIS_E);
        hs_n      = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vs_n      = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        in_win    = (h_cnt >= WX_START) && (h_cnt < WX_END) &&
                    (v_cnt >= WY_START) && (v_cnt < WY_END);
        first     = (h_cnt == '0) && (v_cnt == '0);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/vga_frame_reader.sv
// Display-side image reader: walks the window in raster order issuing port-b reads,
// delays the timing flags to line up with the returned pixels, and registers the pins.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int          H_VISIBLE    = DEF_H_VISIBLE,
    parameter int          H_FP         = DEF_H_FP,
    parameter int          H_SYNC       = DEF_H_SYNC,
    parameter int          H_BP         = DEF_H_BP,
    parameter int          V_VISIBLE    = DEF_V_VISIBLE,
    parameter int          V_FP         = DEF_V_FP,
    parameter int          V_SYNC       = DEF_V_SYNC,
    parameter int          V_BP         = DEF_V_BP,
    parameter int          WIN_X0       = DEF_WIN_X0,
    parameter int          WIN_Y0       = DEF_WIN_Y0,
    parameter int          WIN_W        = DEF_WIN_W,
    parameter int          WIN_H        = DEF_WIN_H,
    parameter int          READ_LATENCY = DEF_READ_LATENCY,
    parameter logic [23:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] frame_base,
    input  logic [23:0]       read_data_b,
    output logic [ADDR_W-1:0] address_b,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              frame_start
);

    tflags_t           cur;
    tflags_t           pipe [READ_LATENCY];
    tflags_t           tail;
    logic              frame_end;
    logic [ADDR_W-1:0] addr;
    rgb_t              rgb_q;

    vga_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_VISIBLE (V_VISIBLE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .WIN_X0    (WIN_X0),    .WIN_Y0 (WIN_Y0), .WIN_W (WIN_W), .WIN_H (WIN_H)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .visible   (cur.visible),
        .hs_n      (cur.hs_n),
        .vs_n      (cur.vs_n),
        .in_win    (cur.in_win),
        .first     (cur.first),
        .frame_end (frame_end)
    );

    // Reloading from frame_base only at the last position of the frame makes the
    // base a per-frame latch; the raster walk then yields base + y*WIN_W + x.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr <= '0;
        end else if (frame_end) begin
            addr <= frame_base;
        end else if (cur.in_win) begin
            addr <= addr + 1'b1;
        end
    end

    assign address_b = addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= FLAGS_IDLE;
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tail = pipe[READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_q       <= '0;
            vga_hsync   <= 1'b1;
            vga_vsync   <= 1'b1;
            vga_blank_n <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (!tail.visible) begin
                rgb_q <= '0;
            end else if (tail.in_win) begin
                rgb_q <= read_data_b;
            end else begin
                rgb_q <= BG_COLOR;
            end
            vga_hsync   <= tail.hs_n;
            vga_vsync   <= tail.vs_n;
            vga_blank_n <= tail.visible;
            frame_start <= tail.first;
        end
    end

    assign vga_r      = rgb_q.r;
    assign vga_g      = rgb_q.g;
    assign vga_b      = rgb_q.b;
    assign vga_sync_n = 1'b0;

endmodule
